rw_pulse_monitor: RTL and testbench
===================================

# rw_pulse_monitor

- Synthesisable, parametrised monitor for NCH independent write/read strobe channels sharing one `done` strobe.
- Per channel it counts `wr`/`rd` rising edges up to EXP_CNT and checks every `rd` pulse is high for exactly RD_HOLD cycles.
- After the count is reached, it requires all strobes to stay quiet until `done` rises, then reports pass or fail with a cause code.
- Sits beside the traffic generator / DUT boundary as an in-design checker, so the same rules can run in silicon, emulation and simulation.

## Interface
Parameters:
- NCH, 2, number of channels
- EXP_CNT, 5, rising edges expected per channel on each of `wr` and `rd` (≥1)
- RD_HOLD, 2, required `rd` high time in cycles (≥1)
- TIMEOUT, 64, cycle budget from arming to `done`; used only with the timeout feature

Ports (CNT_W = $clog2(EXP_CNT+1)):
- clk  in  1  single clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- wr  in  NCH  write strobes
- rd  in  NCH  read strobes
- done  in  1  shared completion strobe
- wr_cnt  out  NCH*CNT_W  per-channel `wr` rise count, saturating
- rd_cnt  out  NCH*CNT_W  per-channel `rd` rise count, saturating
- rd_width_err  out  NCH  one-cycle pulse on an `rd` width violation
- pass  out  NCH  sticky per-channel pass
- fail  out  NCH  sticky per-channel fail
- fail_code  out  NCH*2  per-channel cause: 0 none, 1 early done, 2 extra pulse, 3 timeout
- all_pass  out  1  AND of `pass`

## Operation
- Edge detection:
  - Registered copies of `wr`, `rd` and `done` are kept; all reset to 0.
  - A rise is `x & ~x_q`.
- Per-channel FSM states: IDLE, COUNT, DRAIN, PASS, FAIL.
  - IDLE: held while `rst`=1; moves to COUNT on the first cycle with `rst`=0.
  - COUNT: each `wr` rise increments `wr_cnt`; each `rd` rise increments `rd_cnt`.
    - When both counts equal EXP_CNT after this cycle's update, go to DRAIN.
    - A `done` rise in COUNT goes to FAIL with code 1.
  - DRAIN: any `wr` or `rd` rise goes to FAIL with code 2.
    - A `done` rise with `wr`=0 and no `rd` hold in progress goes to PASS.
    - A `done` rise while an `rd` hold is still in progress goes to FAIL with code 1.
  - PASS / FAIL: terminal until `rst`.
- Counters saturate at EXP_CNT. A further rise in COUNT on an already-saturated counter goes to FAIL with code 2.
- Priority within one cycle:
  - Extra-pulse check first, then `done`.
  - A simultaneous `done` rise and final `wr` rise in COUNT goes to FAIL with code 1.
- `rd` width checker (independent of the FSM, active in every state except IDLE):
  - An `rd` rise loads the hold counter with 1; it increments each further cycle `rd`=1.
  - If `rd` falls with the counter ≠ RD_HOLD, pulse `rd_width_err`.
  - If `rd` is still high when the counter = RD_HOLD, pulse `rd_width_err` once and stop counting until `rd` falls.
  - `rd_width_err` does not alter the FSM.
- Reset mid-operation: all state, counters and outputs return to their reset values on the next posedge.
- Reset value of every output is 0.

## Timing
- All outputs are registered. A strobe sampled at posedge N is reflected in the outputs after posedge N+1 (1-cycle latency).
- `pass`/`fail` rise one cycle after the sampled `done` rise.
- `rd_width_err` is one cycle wide, issued the cycle after the falling or overlong sample.
- No input handshake; strobes may be asserted for any length, and only rises are counted.

## Configuration
- RW_PULSE_MONITOR_TIMEOUT_EN defined:
  - A shared cycle counter starts at the IDLE→COUNT transition.
  - When it reaches TIMEOUT, every channel still in COUNT/DRAIN goes to FAIL with code 3 on that cycle.
  - The counter stops afterwards.
- Undefined: counter logic is absent, TIMEOUT is ignored, and code 3 is never produced.

## Structure
- Package `rw_pulse_monitor_pkg` holds:
  - the FSM state enum
  - the fail-code enum (2-bit)
  - a width helper function for CNT_W
- Sub-module `rw_pulse_monitor_chan`:
  - one channel's edge detect, counters, FSM and width checker
  - instantiated NCH times by generate
- The top level holds:
  - the `done` edge detect
  - the timeout counter
  - the `all_pass` reduction and output packing

## Test plan
- Nominal: NCH=2, 5 one-cycle `wr` pulses and 5 two-cycle `rd` pulses per channel, gaps 1–3 cycles, then a `done` pulse → `pass`=2'b11, `all_pass`=1, counts=5, no `rd_width_err`.
- `rd` held 3 cycles once on ch0 (RD_HOLD=2) → exactly one `rd_width_err[0]` pulse; ch0 still passes.
- Sixth `wr` rise on ch1 before `done` → `fail[1]`=1, `fail_code` ch1 = 2, ch0 passes.
- `done` rises after only 4 `rd` pulses on ch0 → `fail[0]`=1, code 1, `wr_cnt` ch0 = 5, `rd_cnt` ch0 = 4.
- With RW_PULSE_MONITOR_TIMEOUT_EN, TIMEOUT=64, `done` never driven → both channels fail with code 3 at cycle 64 after arming. Without the macro → the channels stay in DRAIN.
- `rst` asserted for one cycle mid-sequence → all outputs read 0 the next cycle, then the nominal sequence passes.

Source files
------------

// File: rtl/rw_pulse_monitor_pkg.sv
// Shared types and helpers for the rw_pulse_monitor checker: channel FSM states,
// 2-bit fail cause codes and the counter-width helper.
package rw_pulse_monitor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COUNT = 3'd1,
    ST_DRAIN = 3'd2,
    ST_PASS  = 3'd3,
    ST_FAIL  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    FC_NONE        = 2'd0,
    FC_EARLY_DONE  = 2'd1,
    FC_EXTRA_PULSE = 2'd2,
    FC_TIMEOUT     = 2'd3
  } fail_code_e;

  // Bits needed to hold values 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rw_pulse_monitor_chan.sv
// One monitored channel: wr/rd edge detect, saturating rise counters,
// pass/fail FSM and the rd pulse-width checker.
module rw_pulse_monitor_chan
  import rw_pulse_monitor_pkg::*;
#(
  parameter int EXP_CNT = 5,
  parameter int RD_HOLD = 2,
  parameter int CNT_W   = cnt_width(EXP_CNT)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr,
  input  logic             i_rd,
  input  logic             i_done_rise,
  input  logic             i_tmo_hit,
  output logic [CNT_W-1:0] o_wr_cnt,
  output logic [CNT_W-1:0] o_rd_cnt,
  output logic             o_rd_width_err,
  output logic             o_pass,
  output logic             o_fail,
  output logic [1:0]       o_fail_code
);

  localparam int                HOLD_W = cnt_width(RD_HOLD);
  localparam logic [CNT_W-1:0]  EXP_C  = CNT_W'(EXP_CNT);
  localparam logic [HOLD_W-1:0] HOLD_C = HOLD_W'(RD_HOLD);

  state_e            r_state, w_state_nxt;
  fail_code_e        r_code, w_code_nxt;
  logic              r_wr_q, r_rd_q;
  logic [CNT_W-1:0]  r_wr_cnt, r_rd_cnt, w_wr_cnt_nxt, w_rd_cnt_nxt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_hold_stop, r_width_err, r_pass, r_fail;
  logic              w_wr_rise, w_rd_rise, w_wr_sat, w_rd_sat, w_extra;

  assign w_wr_rise = i_wr & ~r_wr_q;
  assign w_rd_rise = i_rd & ~r_rd_q;
  assign w_wr_sat  = (r_wr_cnt == EXP_C);
  assign w_rd_sat  = (r_rd_cnt == EXP_C);
  assign w_extra   = (w_wr_rise & w_wr_sat) | (w_rd_rise & w_rd_sat);

  // Next-state, counter and cause-code decode; extra pulses outrank done.
  always_comb begin
    w_state_nxt  = r_state;
    w_code_nxt   = r_code;
    w_wr_cnt_nxt = r_wr_cnt;
    w_rd_cnt_nxt = r_rd_cnt;
    case (r_state)
      ST_IDLE: w_state_nxt = ST_COUNT;
      ST_COUNT: begin
        if (w_wr_rise && !w_wr_sat) w_wr_cnt_nxt = r_wr_cnt + CNT_W'(1);
        else                        w_wr_cnt_nxt = r_wr_cnt;
        if (w_rd_rise && !w_rd_sat) w_rd_cnt_nxt = r_rd_cnt + CNT_W'(1);
        else                        w_rd_cnt_nxt = r_rd_cnt;
        if (i_tmo_hit) begin
          w_state_nxt = ST_FAIL;
          w_code_nxt  = FC_TIMEOUT;
        end else if (w_extra) begin
          w_state_nxt = ST_FAIL;
          w_code_nxt  = FC_EXTRA_PULSE;
        end else if (i_done_rise) begin
          w_state_nxt = ST_FAIL;
          w_code_nxt  = FC_EARLY_DONE;
        end else if (w_wr_cnt_nxt == EXP_C && w_rd_cnt_nxt == EXP_C) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_COUNT;
        end
      end
      ST_DRAIN: begin
        if (i_tmo_hit) begin
          w_state_nxt = ST_FAIL;
          w_code_nxt  = FC_TIMEOUT;
        end else if (w_wr_rise || w_rd_rise) begin
          w_state_nxt = ST_FAIL;
          w_code_nxt  = FC_EXTRA_PULSE;
        end else if (i_done_rise && i_rd) begin
          w_state_nxt = ST_FAIL;
          w_code_nxt  = FC_EARLY_DONE;
        end else if (i_done_rise && !i_wr) begin
          w_state_nxt = ST_PASS;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_PASS, ST_FAIL: w_state_nxt = r_state;
      default: begin
        w_state_nxt = ST_IDLE;
        w_code_nxt  = FC_NONE;
      end
    endcase
  end

  // State, counters, edge history and sticky verdict registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_code   <= FC_NONE;
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
      r_wr_q   <= 1'b0;
      r_rd_q   <= 1'b0;
      r_pass   <= 1'b0;
      r_fail   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_code   <= w_code_nxt;
      r_wr_cnt <= w_wr_cnt_nxt;
      r_rd_cnt <= w_rd_cnt_nxt;
      r_wr_q   <= i_wr;
      r_rd_q   <= i_rd;
      r_pass   <= (w_state_nxt == ST_PASS);
      r_fail   <= (w_state_nxt == ST_FAIL);
    end
  end

  // rd high-time checker; an overlong pulse is flagged once, then ignored until rd falls.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hold_cnt  <= '0;
      r_hold_stop <= 1'b0;
      r_width_err <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      r_hold_cnt  <= '0;
      r_hold_stop <= 1'b0;
      r_width_err <= 1'b0;
    end else begin
      r_width_err <= 1'b0;
      if (w_rd_rise) begin
        r_hold_cnt  <= HOLD_W'(1);
        r_hold_stop <= 1'b0;
      end else if (i_rd && r_rd_q) begin
        if (!r_hold_stop && r_hold_cnt == HOLD_C) begin
          r_width_err <= 1'b1;
          r_hold_stop <= 1'b1;
        end else if (!r_hold_stop) begin
          r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
        end else begin
          r_hold_cnt <= r_hold_cnt;
        end
      end else if (!i_rd && r_rd_q) begin
        r_width_err <= !r_hold_stop && (r_hold_cnt != HOLD_C);
        r_hold_cnt  <= '0;
        r_hold_stop <= 1'b0;
      end else begin
        r_hold_cnt <= r_hold_cnt;
      end
    end
  end

  assign o_wr_cnt       = r_wr_cnt;
  assign o_rd_cnt       = r_rd_cnt;
  assign o_rd_width_err = r_width_err;
  assign o_pass         = r_pass;
  assign o_fail         = r_fail;
  assign o_fail_code    = r_code;

endmodule

// File: rtl/rw_pulse_monitor.sv
// rw_pulse_monitor top: shared done edge detect, optional arming timeout
// (enabled by defining RW_PULSE_MONITOR_TIMEOUT_EN) and per-channel checkers.
module rw_pulse_monitor
  import rw_pulse_monitor_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int EXP_CNT = 5,
  parameter int RD_HOLD = 2,
  parameter int TIMEOUT = 64,
  localparam int CNT_W  = cnt_width(EXP_CNT)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NCH-1:0]       i_wr,
  input  logic [NCH-1:0]       i_rd,
  input  logic                 i_done,
  output logic [NCH*CNT_W-1:0] o_wr_cnt,
  output logic [NCH*CNT_W-1:0] o_rd_cnt,
  output logic [NCH-1:0]       o_rd_width_err,
  output logic [NCH-1:0]       o_pass,
  output logic [NCH-1:0]       o_fail,
  output logic [NCH*2-1:0]     o_fail_code,
  output logic                 o_all_pass
);

  logic r_done_q;
  logic w_done_rise;
  logic w_tmo_hit;

  // done edge history, shared by every channel.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_done_q <= 1'b0;
    else       r_done_q <= i_done;
  end

  assign w_done_rise = i_done & ~r_done_q;

`ifdef RW_PULSE_MONITOR_TIMEOUT_EN
  localparam int               TMO_W = cnt_width(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_C = TMO_W'(TIMEOUT);

  logic             r_armed;
  logic [TMO_W-1:0] r_tmo_cnt;

  // Cycle budget from arming; freezes once the limit is reached.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_armed   <= 1'b0;
      r_tmo_cnt <= '0;
    end else begin
      r_armed <= 1'b1;
      if (r_armed && r_tmo_cnt != TMO_C) r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
      else                               r_tmo_cnt <= r_tmo_cnt;
    end
  end

  assign w_tmo_hit = (r_tmo_cnt == TMO_C);
`else
  // No timeout in this build; TIMEOUT only appears in a constant-false term.
  assign w_tmo_hit = (TIMEOUT < 32'sd0);
`endif

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    rw_pulse_monitor_chan #(
      .EXP_CNT (EXP_CNT),
      .RD_HOLD (RD_HOLD),
      .CNT_W   (CNT_W)
    ) u_chan (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_wr           (i_wr[g]),
      .i_rd           (i_rd[g]),
      .i_done_rise    (w_done_rise),
      .i_tmo_hit      (w_tmo_hit),
      .o_wr_cnt       (o_wr_cnt[g*CNT_W +: CNT_W]),
      .o_rd_cnt       (o_rd_cnt[g*CNT_W +: CNT_W]),
      .o_rd_width_err (o_rd_width_err[g]),
      .o_pass         (o_pass[g]),
      .o_fail         (o_fail[g]),
      .o_fail_code    (o_fail_code[g*2 +: 2])
    );
  end

  assign o_all_pass = &o_pass;

endmodule

// File: tb/tb_rw_pulse_monitor.sv
// Directed self-checking bench for rw_pulse_monitor (NCH=2, EXP_CNT=5, RD_HOLD=2).
module tb_rw_pulse_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] wr = 2'b00;
  logic [1:0] rd = 2'b00;
  logic       done = 1'b0;
  logic [5:0] wr_cnt, rd_cnt;
  logic [1:0] rd_width_err, pass, fail;
  logic [3:0] fail_code;
  logic       all_pass;

  int n_cmp = 0;
  int n_mis = 0;
  int err0 = 0;
  int err1 = 0;

  rw_pulse_monitor #(.NCH(2), .EXP_CNT(5), .RD_HOLD(2), .TIMEOUT(64)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_wr           (wr),
    .i_rd           (rd),
    .i_done         (done),
    .o_wr_cnt       (wr_cnt),
    .o_rd_cnt       (rd_cnt),
    .o_rd_width_err (rd_width_err),
    .o_pass         (pass),
    .o_fail         (fail),
    .o_fail_code    (fail_code),
    .o_all_pass     (all_pass)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the edge, width errors tallied.
  task automatic step();
    @(posedge clk);
    #1;
    if (rd_width_err[0]) err0++;
    if (rd_width_err[1]) err1++;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr = 2'b00; rd = 2'b00; done = 1'b0;
    step();
    rst = 1'b0;
    step();
    err0 = 0; err1 = 0;
  endtask

  // Pulse k of channel c is issued while k < its count; long0 picks one 3-cycle rd on ch0.
  task automatic run_seq(input int n_iter, input int nw0, input int nr0,
                         input int nw1, input int nr1, input int long0);
    for (int k = 0; k < n_iter; k++) begin
      wr = {(k < nw1), (k < nw0)};
      rd = {(k < nr1), (k < nr0)};
      step();
      wr = 2'b00;
      step();
      if (k == long0) begin
        rd[1] = 1'b0;
        step();
      end
      rd = 2'b00;
      repeat ((k % 3) + 1) step();
    end
  endtask

  task automatic pulse_done();
    done = 1'b1;
    step();
    done = 1'b0;
    step();
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    step();
    step();
    check_eq("reset_wr_cnt", 32'(wr_cnt), 32'd0);
    check_eq("reset_flags", 32'({pass, fail, fail_code, all_pass, rd_width_err}), 32'd0);

    // Nominal: both channels pass
    do_reset();
    run_seq(6, 5, 5, 5, 5, -1);
    check_eq("nom_drain_pass", 32'(pass), 32'd0);
    pulse_done();
    check_eq("nom_pass", 32'(pass), 32'b11);
    check_eq("nom_all_pass", 32'(all_pass), 32'd1);
    check_eq("nom_wr_cnt", 32'(wr_cnt), 32'({3'd5, 3'd5}));
    check_eq("nom_rd_cnt", 32'(rd_cnt), 32'({3'd5, 3'd5}));
    check_eq("nom_width_err", 32'(err0 + err1), 32'd0);
    check_eq("nom_fail", 32'(fail), 32'd0);

    // Overlong rd on ch0: one width error, still passes
    do_reset();
    run_seq(6, 5, 5, 5, 5, 2);
    pulse_done();
    check_eq("long_err0", 32'(err0), 32'd1);
    check_eq("long_err1", 32'(err1), 32'd0);
    check_eq("long_pass", 32'(pass), 32'b11);

    // Sixth wr rise on ch1 in DRAIN
    do_reset();
    run_seq(6, 5, 5, 6, 5, -1);
    pulse_done();
    check_eq("extra_fail", 32'(fail), 32'b10);
    check_eq("extra_pass", 32'(pass), 32'b01);
    check_eq("extra_code", 32'(fail_code), 32'b1000);
    check_eq("extra_all_pass", 32'(all_pass), 32'd0);
    check_eq("extra_wr_cnt", 32'(wr_cnt), 32'({3'd5, 3'd5}));

    // Early done: ch0 has only 4 rd pulses
    do_reset();
    run_seq(6, 5, 4, 5, 5, -1);
    pulse_done();
    check_eq("early_fail", 32'(fail), 32'b01);
    check_eq("early_pass", 32'(pass), 32'b10);
    check_eq("early_code", 32'(fail_code), 32'b0001);
    check_eq("early_wr_cnt", 32'(wr_cnt), 32'({3'd5, 3'd5}));
    check_eq("early_rd_cnt", 32'(rd_cnt), 32'({3'd5, 3'd4}));

    // Reset mid-sequence, then nominal again
    do_reset();
    run_seq(3, 5, 5, 5, 5, -1);
    check_eq("mid_wr_cnt", 32'(wr_cnt), 32'({3'd3, 3'd3}));
    rst = 1'b1;
    step();
    check_eq("mid_rst_cnts", 32'({wr_cnt, rd_cnt}), 32'd0);
    check_eq("mid_rst_flags", 32'({pass, fail, fail_code, all_pass, rd_width_err}), 32'd0);
    rst = 1'b0;
    step();
    err0 = 0; err1 = 0;
    run_seq(6, 5, 5, 5, 5, -1);
    pulse_done();
    check_eq("mid_pass", 32'(pass), 32'b11);
    check_eq("mid_all_pass", 32'(all_pass), 32'd1);

    // done never arrives
    do_reset();
    run_seq(6, 5, 5, 5, 5, -1);
    check_eq("tmo_before", 32'(fail), 32'd0);
    repeat (50) step();
`ifdef RW_PULSE_MONITOR_TIMEOUT_EN
    check_eq("tmo_fail", 32'(fail), 32'b11);
    check_eq("tmo_code", 32'(fail_code), 32'b1111);
`else
    check_eq("notmo_fail", 32'(fail), 32'd0);
    check_eq("notmo_pass", 32'(pass), 32'd0);
    check_eq("notmo_code", 32'(fail_code), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
